// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          IMEM_ADDR_W      = 6;

   // Branch immediate is a signed word offset; turn it into a byte offset.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   // A byte address is outside the ROM when its word index reaches the depth.
   function automatic logic out_of_range(input logic [31:0] addr, input int depth);
      return (addr[31:2] >= 30'(depth));
   endfunction

endpackage

// File: rtl/fetch_stage_next_pc_calc.sv
// Combinational next-PC candidates (sequential, branch, jump) with
// out-of-ROM flags for each, so the fetch FSM only has to pick one.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int ROM_DEPTH = 32
) (
   input  logic [31:0] pc,
   input  logic [31:0] if_pc_plus4,
   input  logic [15:0] branch_imm,
   input  logic [25:0] jump_index,
   output logic [31:0] seq_pc,
   output logic [31:0] branch_pc,
   output logic [31:0] jump_pc,
   output logic        seq_oor,
   output logic        branch_oor,
   output logic        jump_oor
);

   // Targets are relative to the instruction in the IF/ID latch, not the fetch PC.
   always_comb begin
      seq_pc     = pc + 32'd4;
      branch_pc  = if_pc_plus4 + branch_offset(branch_imm);
      jump_pc    = {if_pc_plus4[31:28], jump_index, 2'b00};
      seq_oor    = out_of_range(seq_pc, ROM_DEPTH);
      branch_oor = out_of_range(branch_pc, ROM_DEPTH);
      jump_oor   = out_of_range(jump_pc, ROM_DEPTH);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, combinational ROM addressing,
// IF/ID latch, redirect/stall handling and halt-on-overrun.
// Handshake: stall=1 means decode cannot accept; PC and latch hold.
// Redirects (jump, branch_taken) refer to the word in the IF/ID latch and
// are honoured only while if_valid=1; they win over stall.
// Optional: HALT_ON_SELF_JUMP_EN makes a jump to its own address halt fetch.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          ROM_DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [15:0]            branch_imm,
   input  logic                   jump,
   input  logic [25:0]            jump_index,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]            imem_instr,
   output logic [31:0]            if_instr,
   output logic [31:0]            if_pc,
   output logic [31:0]            if_pc_plus4,
   output logic                   if_valid,
   output logic                   halted,
   output logic [31:0]            fetch_count
);

   fetch_state_e state, state_nx;
   logic [31:0]  pc, pc_nx;
   logic [31:0]  instr_nx, if_pc_nx, count_nx;
   logic         valid_nx;
   logic [31:0]  seq_pc, branch_pc, jump_pc;
   logic         seq_oor, branch_oor, jump_oor;
   logic         self_jump;

   assign imem_addr   = pc[IMEM_ADDR_W+1:2];
   assign if_pc_plus4 = if_pc + 32'd4;
   assign halted      = (state == HALT);

`ifdef HALT_ON_SELF_JUMP_EN
   assign self_jump = (jump_pc == if_pc);
`else
   assign self_jump = 1'b0;
`endif

   next_pc_calc #(.ROM_DEPTH(ROM_DEPTH)) u_next_pc (
      .pc          (pc),
      .if_pc_plus4 (if_pc_plus4),
      .branch_imm  (branch_imm),
      .jump_index  (jump_index),
      .seq_pc      (seq_pc),
      .branch_pc   (branch_pc),
      .jump_pc     (jump_pc),
      .seq_oor     (seq_oor),
      .branch_oor  (branch_oor),
      .jump_oor    (jump_oor)
   );

   // State and IF/ID latch registers; reset aborts any stall or redirect at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         if_instr    <= 32'd0;
         if_pc       <= 32'd0;
         if_valid    <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         if_instr    <= instr_nx;
         if_pc       <= if_pc_nx;
         if_valid    <= valid_nx;
         fetch_count <= count_nx;
      end
   end

   // Next state: jump > branch > stall > sequential; HALT only drops the valid bit.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      instr_nx = if_instr;
      if_pc_nx = if_pc;
      valid_nx = if_valid;
      count_nx = fetch_count;
      if (state == RUN) begin
         if (if_valid && jump) begin
            valid_nx = 1'b0;
            if (self_jump) begin
               state_nx = HALT;
            end else begin
               pc_nx = jump_pc;
               if (jump_oor) state_nx = HALT;
            end
         end else if (if_valid && branch_taken) begin
            valid_nx = 1'b0;
            pc_nx    = branch_pc;
            if (branch_oor) state_nx = HALT;
         end else if (!stall) begin
            instr_nx = imem_instr;
            if_pc_nx = pc;
            valid_nx = 1'b1;
            count_nx = fetch_count + 32'd1;
            pc_nx    = seq_pc;
            // The word just latched is real; only the new pc is off the end.
            if (seq_oor) state_nx = HALT;
         end
      end else begin
         valid_nx = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/branch/jump traffic, all compared against a behavioural model.
module tb_fetch_stage;

   localparam int DEPTH = 18;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic [5:0]  imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        halted;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] rom [0:63];

   // model state
   logic [31:0] m_pc, m_instr, m_if_pc, m_count;
   logic        m_valid, m_halted;

   fetch_stage #(.RESET_PC(32'h0), .ROM_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_index   (jump_index),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pc_plus4  (if_pc_plus4),
      .if_valid     (if_valid),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   assign imem_instr = rom[imem_addr];

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".instr"}, if_instr, m_instr);
      check({tag, ".if_pc"}, if_pc, m_if_pc);
      check({tag, ".pc4"}, if_pc_plus4, m_if_pc + 32'd4);
      check({tag, ".valid"}, 32'(if_valid), 32'(m_valid));
      check({tag, ".halted"}, 32'(halted), 32'(m_halted));
      check({tag, ".count"}, fetch_count, m_count);
      check({tag, ".addr"}, 32'(imem_addr), 32'(m_pc[7:2]));
   endtask

   function automatic logic past_rom(input logic [31:0] a);
      return (a / 4) >= DEPTH;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_if_pc = 32'h0;
      m_count = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
   endtask

   // One clock of fetch behaviour, stated directly from the rules.
   task automatic model_update();
      logic [31:0] tgt, sx;
      if (m_halted) begin
         m_valid = 1'b0;
      end else if (m_valid && jump) begin
         tgt = ((m_if_pc + 32'd4) & 32'hF000_0000) | (32'(jump_index) * 4);
         m_valid = 1'b0;
`ifdef HALT_ON_SELF_JUMP_EN
         if (tgt == m_if_pc) m_halted = 1'b1;
         else begin
            m_pc = tgt;
            if (past_rom(tgt)) m_halted = 1'b1;
         end
`else
         m_pc = tgt;
         if (past_rom(tgt)) m_halted = 1'b1;
`endif
      end else if (m_valid && branch_taken) begin
         sx  = {{16{branch_imm[15]}}, branch_imm};
         tgt = m_if_pc + 32'd4 + sx * 4;
         m_valid = 1'b0;
         m_pc = tgt;
         if (past_rom(tgt)) m_halted = 1'b1;
      end else if (!stall) begin
         m_instr = rom[m_pc[7:2]];
         m_if_pc = m_pc;
         m_valid = 1'b1;
         m_count = m_count + 32'd1;
         m_pc    = m_pc + 32'd4;
         if (past_rom(m_pc)) m_halted = 1'b1;
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_all("step");
   endtask

   task automatic clear_inputs();
      stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'h0;
      jump = 1'b0; jump_index = 26'h0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      reset_n = 1'b1;
   endtask

   task automatic run_to(input logic [31:0] tgt);
      int n = 0;
      clear_inputs();
      while (!(m_valid && m_if_pc == tgt) && !m_halted && n < 40) begin
         step();
         n++;
      end
      check("run_to", m_if_pc, tgt);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      rom[0]  = 32'h2002_0005; rom[1]  = 32'h2003_000c; rom[2]  = 32'h2067_fff7;
      rom[3]  = 32'h00e2_2025; rom[4]  = 32'h0064_2824; rom[5]  = 32'h00a4_2820;
      rom[6]  = 32'h10a7_000a; rom[7]  = 32'h0064_202a; rom[8]  = 32'h1080_0001;
      rom[9]  = 32'h2005_0000; rom[10] = 32'h00e2_202a; rom[11] = 32'h0085_3820;
      rom[12] = 32'h00e2_3822; rom[13] = 32'hac67_0044; rom[14] = 32'h8c02_0050;
      rom[15] = 32'h0800_0011; rom[16] = 32'h2002_0001; rom[17] = 32'hac02_0054;

      clear_inputs();
      reset_n = 1'b0;
      model_reset();
      #2;
      do_reset();

      // sequential fetch of the first three words
      step(); step(); step();
      check("t1.pc", if_pc, 32'h8);
      check("t1.instr", if_instr, 32'h2067_fff7);
      check("t1.count", fetch_count, 32'd3);

      // stall two cycles with pc=0xc
      stall = 1'b1;
      step();
      check("t2.addr", 32'(imem_addr), 32'd3);
      step();
      check("t2.count", fetch_count, 32'd3);
      stall = 1'b0;
      step();
      check("t2.resume", if_pc, 32'hc);

      // taken branch at 0x18 -> 0x44, then overrun halts
      run_to(32'h18);
      branch_taken = 1'b1; branch_imm = 16'h000a;
      step();
      check("t3.bubble", 32'(if_valid), 32'd0);
      clear_inputs();
      step();
      check("t3.pc", if_pc, 32'h44);
      check("t3.instr", if_instr, 32'hac02_0054);
      check("t5.halted", 32'(halted), 32'd1);
      check("t5.addr", 32'(imem_addr), 32'd18);
      stall = 1'b1; jump = 1'b1; jump_index = 26'h3; branch_taken = 1'b1;
      step(); step(); step();
      check("t5.frozen", 32'(imem_addr), 32'd18);
      check("t5.valid", 32'(if_valid), 32'd0);

      // reset asserted mid-stall, no clock edge
      do_reset();
      step(); step();
      stall = 1'b1;
      step();
      #2;
      do_reset();
      clear_inputs();

      // jump+branch together at 0x3c -> jump target wins
      run_to(32'h3c);
      jump = 1'b1; jump_index = 26'h11; branch_taken = 1'b1; branch_imm = 16'h0002;
      step();
      clear_inputs();
      step();
      check("t4.pc", if_pc, 32'h44);

      // self jump at 0x3c
      do_reset();
      run_to(32'h3c);
      jump = 1'b1; jump_index = 26'h0f;
      step();
`ifdef HALT_ON_SELF_JUMP_EN
      check("t6.halted", 32'(halted), 32'd1);
`else
      check("t6.bubble", 32'(if_valid), 32'd0);
      clear_inputs();
      step();
      check("t6.loop", if_pc, 32'h3c);
`endif

      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (m_halted && $urandom_range(0, 3) == 0) begin
            clear_inputs();
            do_reset();
         end
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 5) == 0);
         branch_imm   = ($urandom_range(0, 9) == 0) ? 16'($urandom) :
                                                       16'($urandom_range(0, 24)) - 16'd12;
         jump         = ($urandom_range(0, 7) == 0);
         jump_index   = 26'($urandom_range(0, 19));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
